// File: rtl/ycfsm_sync.sv
// ycfsm_sync: per-cell token latch for a Morphle Logic y-cell.
// It captures one dual-rail input token and one dual-rail match token and
// presents their AND on `out`. The result is held until both upstream inputs
// return to a not-valid code, and then both latches clear together.
module ycfsm_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] in,
  input  logic [1:0] match,
  output logic [1:0] out
);

  typedef enum logic [1:0] {
    VEMPTY = 2'b00,
    V0     = 2'b01,
    V1     = 2'b10
  } tok_e;

  tok_e lin;
  tok_e lmatch;
  tok_e lin_nxt;
  tok_e lmatch_nxt;

  // Only V0/V1 are tokens. 2'b11 is treated like empty, so it is never latched.
  function automatic logic is_valid(input logic [1:0] t);
    return (t == V0) || (t == V1);
  endfunction

  // AND of two dual-rail tokens. The result is empty unless both are present.
  function automatic tok_e combine(input tok_e a, input tok_e b);
    if (!is_valid(a) || !is_valid(b)) begin
      return VEMPTY;
    end else if ((a == V1) && (b == V1)) begin
      return V1;
    end else begin
      return V0;
    end
  endfunction

  // Next token state. A clear needs both inputs to be not valid, so a clear
  // and a load can never happen on the same edge. A held token ignores any
  // later change on its input.
  always_comb begin
    lin_nxt    = lin;
    lmatch_nxt = lmatch;
    if (is_valid(lin) && is_valid(lmatch) && !is_valid(in) && !is_valid(match)) begin
      lin_nxt    = VEMPTY;
      lmatch_nxt = VEMPTY;
    end else begin
      if (!is_valid(lin) && is_valid(in)) begin
        lin_nxt = tok_e'(in);
      end
      if (!is_valid(lmatch) && is_valid(match)) begin
        lmatch_nxt = tok_e'(match);
      end
    end
  end

  // Token latches and registered result. `out` is computed from the next
  // register values, so after every edge it equals combine(lin, lmatch).
  // There is no path from the live inputs to `out`.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lin    <= VEMPTY;
      lmatch <= VEMPTY;
      out    <= VEMPTY;
    end else begin
      lin    <= lin_nxt;
      lmatch <= lmatch_nxt;
      out    <= combine(lin_nxt, lmatch_nxt);
    end
  end

endmodule

// File: tb/tb_ycfsm_sync.sv
// tb_ycfsm_sync: directed vector table, hand-written reset/isolation
// sequences and a randomized phase against a token-level reference model.
module tb_ycfsm_sync;

  localparam logic [1:0] E  = 2'b00;
  localparam logic [1:0] Z  = 2'b01;  // V0
  localparam logic [1:0] O  = 2'b10;  // V1
  localparam logic [1:0] BAD = 2'b11;

  logic       clk;
  logic       reset_n;
  logic [1:0] in;
  logic [1:0] match;
  logic [1:0] out;

  int checks = 0;
  int errors = 0;

  ycfsm_sync dut (
    .clk    (clk),
    .reset_n(reset_n),
    .in     (in),
    .match  (match),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] vin;
    logic [1:0] vmatch;
    logic [1:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the inputs, take one rising edge, then sample just after it.
  task automatic step(input logic [1:0] vi, input logic [1:0] vm);
    in    = vi;
    match = vm;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in      = E;
    match   = E;
    #1;
    check("reset_async", out, E);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic add(input logic [1:0] vi, input logic [1:0] vm, input logic [1:0] e, input string n);
    vec_t v;
    v.vin = vi; v.vmatch = vm; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // Reference model: each side is either nothing held (-1) or a held bit.
  function automatic bit tok_valid(input logic [1:0] t);
    return (t == 2'b01) || (t == 2'b10);
  endfunction

  function automatic logic [1:0] model_out(input int a, input int b);
    if (a < 0 || b < 0) return 2'b00;
    return (a & b) ? 2'b10 : 2'b01;
  endfunction

  int hin, hm;

  task automatic model_edge(input logic [1:0] vi, input logic [1:0] vm);
    if (hin >= 0 && hm >= 0 && !tok_valid(vi) && !tok_valid(vm)) begin
      hin = -1;
      hm  = -1;
    end else begin
      if (hin < 0 && tok_valid(vi)) hin = (vi == 2'b10) ? 1 : 0;
      if (hm  < 0 && tok_valid(vm)) hm  = (vm == 2'b10) ? 1 : 0;
    end
  endtask

  function automatic logic [1:0] rand_tok();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return E;
    if (r < 6) return Z;
    if (r < 9) return O;
    return BAD;
  endfunction

  initial begin
    reset_n = 1'b0;
    in      = E;
    match   = E;
    #12;
    check("reset_state", out, E);
    @(negedge clk);
    reset_n = 1'b1;

    // Scenario 1: in first, then match, then drop match before in.
    add(O, E, E, "s1_in_only");
    add(O, O, O, "s1_both_v1");
    add(O, E, O, "s1_match_drop_hold");
    add(E, E, E, "s1_clear");
    // Scenario 2: a short match pulse is held until in arrives.
    add(E, Z, E, "s2_match_pulse");
    add(E, E, E, "s2_lone_match_held");
    add(O, E, Z, "s2_in_completes");
    // Scenario 3: a held token ignores later changes on its input.
    add(O, O, Z, "s3_match_change_ignored");
    add(E, O, Z, "s3_in_empty_match_valid");
    add(Z, O, Z, "s3_in_v0");
    add(Z, E, Z, "s3_match_empty_in_valid");
    add(E, E, E, "s3_clear");
    // Scenario 4: simultaneous arrival of both tokens.
    add(Z, Z, Z, "s4_v0_v0");
    add(E, E, E, "s4_clear_a");
    add(O, Z, Z, "s4_v1_v0");
    add(E, E, E, "s4_clear_b");
    add(Z, O, Z, "s4_v0_v1");
    add(E, E, E, "s4_clear_c");
    // Scenario 6: an illegal code on in is never latched.
    add(BAD, O, E, "s6_illegal_in");
    add(O, O, O, "s6_then_v1");
    add(E, E, E, "s6_clear");
    // 2'b11 on both inputs counts as not valid and clears a full cell.
    add(Z, Z, Z, "bad_full_load");
    add(BAD, BAD, E, "bad_clears");
    add(E, E, E, "bad_idle");
    // A change from V1 to V0 after loading is ignored.
    add(O, O, O, "v1_load");
    add(Z, O, O, "v1_to_v0_ignored");
    add(E, E, E, "v1_clear");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vin, vecs[i].vmatch);
      check(vecs[i].name, out, vecs[i].exp);
    end

    // No path from the inputs to out: change the inputs between edges.
    @(negedge clk);
    in = O; match = O;
    #2;
    check("no_comb_path", out, E);
    @(posedge clk); #1;
    check("s5_loaded", out, O);

    // Scenario 5: an asynchronous reset in the middle of a token.
    #2;
    reset_n = 1'b0;
    #1;
    check("s5_async_reset", out, E);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("s5_no_edge_yet", out, E);
    @(posedge clk); #1;
    check("s5_reload_after_reset", out, O);

    // Randomized phase against the reference model.
    do_reset();
    hin = -1;
    hm  = -1;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] vi, vm;
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
        hin = -1;
        hm  = -1;
      end
      vi = rand_tok();
      vm = rand_tok();
      step(vi, vm);
      model_edge(vi, vm);
      check("random", out, model_out(hin, hm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: out=%b expected=finish", out);
    $fatal(1, "timeout");
  end

endmodule
